ifu_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the instruction decoder.

---
 rtl/npc_pkg.sv | 17 +
 rtl/ifu_fetch.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default reset PC, canonical NOP encoding and the supported data width.
package npc_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one memory read per instruction, {inst, pc} handed to decode.
// Optional misaligned-PC fault slot is enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC_DEFAULT,
    parameter int          XLEN     = npc_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault
);
    import npc_pkg::*;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            flush_q;
    logic            halted_q;

    logic misaligned;
    logic fault_slot;
    logic req_fire;
    logic hand_off;
    logic halt_now;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned PC turns the request slot into a synthetic NOP handed to decode.
    assign fault_slot  = (state_q == S_REQ) && misaligned;
    assign fetch_fault = fault_slot;

    assign imem_req_valid = (state_q == S_REQ) && !misaligned;
    assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};

    assign inst_valid = ((state_q == S_HOLD) || fault_slot) && !redirect_valid;
    assign inst       = fault_slot ? INST_NOP : inst_q;
    assign pc         = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign hand_off = inst_valid && inst_ready;
    assign halt_now = halt || halted_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            if (halt) begin
                halted_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    state_q <= halt_now ? S_HALT : S_REQ;
                end

                S_REQ: begin
                    if (req_fire) begin
                        // The accepted read must still be drained; its data is stale.
                        if (redirect_valid) begin
                            pc_q    <= redirect_pc;
                            flush_q <= 1'b1;
                        end
                        state_q <= S_WAIT;
                    end else begin
                        if (redirect_valid) begin
                            pc_q <= redirect_pc;
                        end else if (hand_off) begin
                            pc_q <= pc_q + XLEN'(4);
                        end
                        if (halt_now) begin
                            state_q <= S_HALT;
                        end
                    end
                end

                S_WAIT: begin
                    if (imem_resp_valid) begin
                        flush_q <= 1'b0;
                        if (redirect_valid) begin
                            pc_q <= redirect_pc;
                        end
                        if (halt_now) begin
                            state_q <= S_HALT;
                        end else if (redirect_valid || flush_q) begin
                            state_q <= S_REQ;
                        end else begin
                            inst_q  <= imem_resp_data;
                            state_q <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        flush_q <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= halt_now ? S_HALT : S_REQ;
                    end else if (hand_off) begin
                        pc_q    <= pc_q + XLEN'(4);
                        state_q <= halt_now ? S_HALT : S_REQ;
                    end
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: random memory/decode timing against an
// architectural PC-stream model plus directed redirect, stall, halt and wrap cases.
module tb_ifu_fetch;
    import npc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk             = 1'b0;
    logic        rst             = 1'b1;
    logic        redirect_valid  = 1'b0;
    logic [31:0] redirect_pc     = '0;
    logic        halt            = 1'b0;
    logic        imem_req_ready  = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        inst_ready      = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_fault;

    ifu_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Stimulus knobs, written only by the main initial block at posedge.
    int          ready_pct    = 100;
    int          iready_pct   = 100;
    int          lat_min      = 1;
    int          lat_max      = 1;
    int          redir_pct    = 0;
    bit          rst_k        = 1'b1;
    bit          halt_k       = 1'b0;
    int          redir_req_id = 0;
    logic [31:0] redir_target = '0;

    // Driver-owned state.
    int cyc           = 0;
    int redir_done_id = 0;

    // Monitor-owned model state.
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_inst;
    logic        exp_fault;
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          pend_due   = 0;
    logic [31:0] req_log[$];
    logic [31:0] hand_log[$];
    bit          prev_req_wait  = 1'b0;
    bit          prev_hold_wait = 1'b0;
    bit          iv_now         = 1'b0;
    logic [31:0] prev_addr, prev_inst, prev_pc;

    always @(posedge clk) begin
        #1;
        cyc            = cyc + 1;
        rst            = rst_k;
        halt           = halt_k;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        inst_ready     = ($urandom_range(99) < iready_pct);
        if (pend_valid && cyc >= pend_due) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        if (redir_req_id != redir_done_id) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_done_id  = redir_req_id;
        end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = RST_PC + ($urandom_range(255) << 2);
        end else begin
            redirect_valid = 1'b0;
        end
    end

    // Reference model: the architectural PC stream plus a one-deep memory.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc         = RST_PC;
            pend_valid     = 1'b0;
            prev_req_wait  = 1'b0;
            prev_hold_wait = 1'b0;
            iv_now         = 1'b0;
        end else begin
            iv_now = inst_valid;
            if (redirect_valid)
                check("no_handoff_on_redirect", 32'(inst_valid), 32'd0);
            if (prev_req_wait) begin
                check("req_valid_held", 32'(imem_req_valid), 32'd1);
                check("req_addr_stable", imem_req_addr, prev_addr);
            end
            if (prev_hold_wait && !redirect_valid) begin
                check("inst_valid_held", 32'(inst_valid), 32'd1);
                check("inst_stable", inst, prev_inst);
                check("pc_stable", pc, prev_pc);
                check("no_req_while_holding", 32'(imem_req_valid), 32'd0);
            end
            if (imem_resp_valid) pend_valid = 1'b0;
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, {exp_pc[31:2], 2'b00});
`ifdef IFU_MISALIGN_CHECK_EN
                check("req_aligned_only", 32'(exp_pc[1:0]), 32'd0);
`endif
                if (imem_req_ready) begin
                    check("one_outstanding", 32'(pend_valid), 32'd0);
                    pend_valid = 1'b1;
                    pend_addr  = imem_req_addr;
                    pend_due   = cyc + int'($urandom_range(lat_max, lat_min));
                    req_log.push_back(imem_req_addr);
                end
            end
            if (inst_valid && inst_ready) begin
                exp_inst  = mem_word({exp_pc[31:2], 2'b00});
                exp_fault = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
                if (exp_pc[1:0] != 2'b00) begin
                    exp_inst  = INST_NOP;
                    exp_fault = 1'b1;
                end
`endif
                check("handoff_pc", pc, exp_pc);
                check("handoff_inst", inst, exp_inst);
                check("handoff_fault", 32'(fetch_fault), 32'(exp_fault));
                hand_log.push_back(pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            prev_req_wait  = imem_req_valid && !imem_req_ready && !redirect_valid && !halt;
            prev_addr      = imem_req_addr;
            prev_hold_wait = inst_valid && !inst_ready;
            prev_inst      = inst;
            prev_pc        = pc;
        end
    end

    task automatic wait_reqs(input int n, input string tag);
        for (int i = 0; i < 400 && req_log.size() < n; i++) @(posedge clk);
        check(tag, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_hands(input int n, input string tag);
        for (int i = 0; i < 400 && hand_log.size() < n; i++) @(posedge clk);
        check(tag, 32'(hand_log.size() >= n), 32'd1);
    endtask

    task automatic wait_hold(input string tag);
        for (int i = 0; i < 400 && !iv_now; i++) @(posedge clk);
        check(tag, 32'(iv_now), 32'd1);
    endtask

    initial begin
        int          r, h, r2, h2, h0;
        logic [31:0] p;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        @(posedge clk);
        rst_k = 1'b0;
        @(negedge clk);
        check("idle_no_req", 32'(imem_req_valid), 32'd0);

        // Sequential fetch, memory latency 1, decode always ready.
        wait_reqs(3, "t1_reqs_timeout");
        wait_hands(3, "t1_hands_timeout");
        check("t1_req0", req_log[0], 32'h8000_0000);
        check("t1_req1", req_log[1], 32'h8000_0004);
        check("t1_req2", req_log[2], 32'h8000_0008);
        check("t1_pc0", hand_log[0], 32'h8000_0000);
        check("t1_pc1", hand_log[1], 32'h8000_0004);
        check("t1_pc2", hand_log[2], 32'h8000_0008);

        // Decode back-pressure while an instruction is held.
        @(posedge clk);
        iready_pct = 0;
        @(posedge clk);
        wait_hold("t2_hold_timeout");
        @(negedge clk);
        p = pc;
        r = req_log.size();
        h = hand_log.size();
        repeat (5) @(negedge clk);
        check("t2_valid", 32'(inst_valid), 32'd1);
        check("t2_pc", pc, p);
        check("t2_no_req", 32'(req_log.size()), 32'(r));
        check("t2_no_hand", 32'(hand_log.size()), 32'(h));

        // Redirect in the hold state while decode is ready.
        @(posedge clk);
        iready_pct   = 100;
        redir_target = 32'h8000_0200;
        redir_req_id++;
        wait_reqs(r + 1, "t4_req_timeout");
        check("t4_req_addr", req_log[r], 32'h8000_0200);
        wait_hands(h + 1, "t4_hand_timeout");
        check("t4_hand_pc", hand_log[h], 32'h8000_0200);

        // Redirect while a read is outstanding.
        lat_min = 4;
        lat_max = 4;
        r = req_log.size();
        h = hand_log.size();
        wait_reqs(r + 1, "t3_accept_timeout");
        redir_target = 32'h8000_0100;
        redir_req_id++;
        wait_reqs(r + 2, "t3_refetch_timeout");
        check("t3_refetch_addr", req_log[r + 1], 32'h8000_0100);
        wait_hands(h + 1, "t3_hand_timeout");
        check("t3_hand_pc", hand_log[h], 32'h8000_0100);

        // Memory back-pressure, then a one-cycle halt pulse.
        lat_min   = 1;
        lat_max   = 1;
        ready_pct = 0;
        r = req_log.size();
        repeat (4) @(negedge clk);
        check("t5_req_valid", 32'(imem_req_valid), 32'd1);
        check("t5_req_addr", imem_req_addr, 32'h8000_0104);
        check("t5_no_accept", 32'(req_log.size()), 32'(r));
        @(posedge clk);
        ready_pct = 100;
        h = hand_log.size();
        wait_hands(h + 1, "t5_hand_timeout");
        halt_k  = 1'b1;
        lat_min = 3;
        lat_max = 3;
        r2 = req_log.size();
        h2 = hand_log.size();
        @(posedge clk);
        halt_k = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_halt_no_hand", 32'(hand_log.size()), 32'(h2));
        check("t5_halt_drain_one", 32'(req_log.size() - r2), 32'd1);
        check("t5_halt_req_valid", 32'(imem_req_valid), 32'd0);
        check("t5_halt_inst_valid", 32'(inst_valid), 32'd0);

        // Reset out of halt, then PC wrap-around.
        @(posedge clk);
        rst_k = 1'b1;
        repeat (2) @(posedge clk);
        rst_k        = 1'b0;
        lat_min      = 1;
        lat_max      = 1;
        redir_target = 32'hFFFF_FFFC;
        redir_req_id++;
        h = hand_log.size();
        wait_hands(h + 2, "wrap_timeout");
        check("wrap_pc0", hand_log[h], 32'hFFFF_FFFC);
        check("wrap_pc1", hand_log[h + 1], 32'h0000_0000);

        // Randomized timing and redirects.
        ready_pct  = 70;
        iready_pct = 70;
        lat_min    = 1;
        lat_max    = 4;
        redir_pct  = 4;
        h0 = hand_log.size();
        repeat (3000) @(posedge clk);
        check("rand_progress", 32'(hand_log.size() - h0 >= 150), 32'd1);
        redir_pct  = 0;
        ready_pct  = 100;
        iready_pct = 100;

`ifdef IFU_MISALIGN_CHECK_EN
        repeat (8) @(posedge clk);
        h = hand_log.size();
        redir_target = 32'h8000_0102;
        redir_req_id++;
        wait_hands(h + 1, "t6_hand_timeout");
        check("t6_fault_pc", hand_log[h], 32'h8000_0102);
        redir_target = RST_PC;
        redir_req_id++;
        h = hand_log.size();
        wait_hands(h + 2, "t6_recover_timeout");
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
